nap_alarm_scheduler: RTL and testbench

Sequential controller that turns the shortcut-setting result (a BCD nap duration) into an absolute wake-up target and then watches the running clock. It adds the duration to a snapshot of the current time one digit per cycle, arms, compares against live time, rings for a fixed window, and supports snooze and cancel. It sits between the shortcut-setting/keypad path and the alarm output driver.

---
 rtl/nap_alarm_scheduler_pkg.sv | 49 ++++
 rtl/nap_alarm_scheduler_bcd_digit_add.sv | 27 ++
 rtl/nap_alarm_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_nap_alarm_scheduler.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/nap_alarm_scheduler_pkg.sv
// nap_alarm_scheduler_pkg
// Shared types and constants for the nap alarm scheduler.
//   - state_e       : controller states
//   - BCD_W/TIME_W  : digit and time-word widths
//   - *_LSB         : bit offsets of each BCD digit inside a time word
//   - MOD_*         : per-digit moduli (decimal, sexagesimal, hour pair)
//   - hour_to_bcd   : binary hour 0..23 -> two BCD digits
package nap_alarm_scheduler_pkg;

  localparam int BCD_W  = 4;
  localparam int TIME_W = 24;

  // Digit layout {h10,h1,m10,m1,s10,s1}
  localparam int S1_LSB  = 0;
  localparam int S10_LSB = 4;
  localparam int M1_LSB  = 8;
  localparam int M10_LSB = 12;
  localparam int H1_LSB  = 16;
  localparam int H10_LSB = 20;

  localparam logic [BCD_W-1:0] MOD_DEC  = 4'd10;
  localparam logic [BCD_W-1:0] MOD_SEX  = 4'd6;
  localparam logic [7:0]       MOD_HOUR = 8'd24;

  // ADD walks steps 0..STEP_LAST; the last step is the hour pair
  localparam logic [2:0] STEP_LAST = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_ARMED = 2'd2,
    ST_RING  = 2'd3
  } state_e;

  // Valid only for 0..29, which covers every reduced hour from BCD inputs.
  function automatic logic [7:0] hour_to_bcd(input logic [7:0] v);
    logic [7:0] rem;
    if (v >= 8'd20) begin
      rem = v - 8'd20;
      return {4'd2, rem[3:0]};
    end else if (v >= 8'd10) begin
      rem = v - 8'd10;
      return {4'd1, rem[3:0]};
    end else begin
      return {4'd0, v[3:0]};
    end
  endfunction

endpackage

// File: rtl/nap_alarm_scheduler_bcd_digit_add.sv
// bcd_digit_add
// Single-digit modular adder used for the seconds/minutes digits.
//   i_a, i_b  : BCD operand digits
//   i_cin     : carry in from the lower digit
//   i_mod     : digit modulus (10 or 6)
//   o_digit   : (a+b+cin) reduced once by the modulus
//   o_cout    : carry to the next digit
module bcd_digit_add
  import nap_alarm_scheduler_pkg::*;
(
  input  logic [BCD_W-1:0] i_a,
  input  logic [BCD_W-1:0] i_b,
  input  logic             i_cin,
  input  logic [BCD_W-1:0] i_mod,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_cout
);

  logic [BCD_W:0] w_sum;
  logic [BCD_W:0] w_diff;

  assign w_sum   = {1'b0, i_a} + {1'b0, i_b} + {{BCD_W{1'b0}}, i_cin};
  assign w_diff  = w_sum - {1'b0, i_mod};
  assign o_cout  = (w_sum >= {1'b0, i_mod});
  assign o_digit = o_cout ? w_diff[BCD_W-1:0] : w_sum[BCD_W-1:0];

endmodule

// File: rtl/nap_alarm_scheduler.sv
// nap_alarm_scheduler
// Turns a BCD nap duration into an absolute wake-up time (one digit per
// cycle), waits for the live clock to reach it, rings for RING_LEN cycles,
// and supports snooze and cancel.
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_start          : schedule i_cur_time + i_offset (IDLE/ARMED only)
//   i_cancel         : return to IDLE from anywhere; target is held
//   i_snooze         : while ringing, schedule i_cur_time + SNOOZE_MIN min
//   i_cur_time       : live time {h10,h1,m10,m1,s10,s1}, BCD
//   i_offset         : nap duration, same layout
//   o_target         : wake-up time (partial while busy)
//   o_busy/o_armed/o_alarm : state ADD / ARMED / RING
module nap_alarm_scheduler
  import nap_alarm_scheduler_pkg::*;
#(
  parameter int RING_LEN   = 16,
  parameter int SNOOZE_MIN = 5
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_cancel,
  input  logic              i_snooze,
  input  logic [TIME_W-1:0] i_cur_time,
  input  logic [TIME_W-1:0] i_offset,
  output logic [TIME_W-1:0] o_target,
  output logic              o_busy,
  output logic              o_armed,
  output logic              o_alarm
);

  localparam int CNT_W = (RING_LEN > 1) ? $clog2(RING_LEN) : 1;
  localparam logic [CNT_W-1:0]  RING_LAST = CNT_W'(RING_LEN - 1);
  localparam logic [TIME_W-1:0] SNOOZE_ADDEND = {12'd0, 4'(SNOOZE_MIN), 8'd0};

  state_e            r_state;
  state_e            w_state_nxt;
  logic [TIME_W-1:0] r_base;
  logic [TIME_W-1:0] r_addend;
  logic [TIME_W-1:0] r_target;
  logic              r_carry;
  logic [2:0]        r_step;
  logic [CNT_W-1:0]  r_ring_cnt;

  logic              w_load_start;
  logic              w_load_snooze;
  logic              w_match;
  logic [BCD_W-1:0]  w_a;
  logic [BCD_W-1:0]  w_b;
  logic [BCD_W-1:0]  w_mod;
  logic [BCD_W-1:0]  w_digit;
  logic              w_cout;
  logic [7:0]        w_hour_sum;
  logic [7:0]        w_hour_red;
  logic [7:0]        w_hour_bcd;

  assign w_match = (i_cur_time == r_target);

  // ---------------- FSM ----------------
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load_start  = 1'b0;
    w_load_snooze = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt  = ST_ADD;
          w_load_start = 1'b1;
        end
      end
      ST_ADD: begin
        if (r_step == STEP_LAST) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        // a re-schedule beats a match seen in the same cycle
        if (i_start) begin
          w_state_nxt  = ST_ADD;
          w_load_start = 1'b1;
        end else if (w_match) begin
          w_state_nxt = ST_RING;
        end
      end
      ST_RING: begin
        if (i_snooze) begin
          w_state_nxt   = ST_ADD;
          w_load_snooze = 1'b1;
        end else if (r_ring_cnt == RING_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_cancel) begin
      w_state_nxt   = ST_IDLE;
      w_load_start  = 1'b0;
      w_load_snooze = 1'b0;
    end
  end

  // ---------------- digit adder ----------------
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_mod = MOD_DEC;
    case (r_step)
      3'd0: begin
        w_a = r_base[S1_LSB +: BCD_W];  w_b = r_addend[S1_LSB +: BCD_W];  w_mod = MOD_DEC;
      end
      3'd1: begin
        w_a = r_base[S10_LSB +: BCD_W]; w_b = r_addend[S10_LSB +: BCD_W]; w_mod = MOD_SEX;
      end
      3'd2: begin
        w_a = r_base[M1_LSB +: BCD_W];  w_b = r_addend[M1_LSB +: BCD_W];  w_mod = MOD_DEC;
      end
      3'd3: begin
        w_a = r_base[M10_LSB +: BCD_W]; w_b = r_addend[M10_LSB +: BCD_W]; w_mod = MOD_SEX;
      end
      default: begin
        w_a   = '0;
        w_b   = '0;
        w_mod = MOD_DEC;
      end
    endcase
  end

  bcd_digit_add u_digit_add (
    .i_a     (w_a),
    .i_b     (w_b),
    .i_cin   (r_carry),
    .i_mod   (w_mod),
    .o_digit (w_digit),
    .o_cout  (w_cout)
  );

  // Hours are added as a binary pair so the 24 wrap is one compare; the
  // final carry out of the hours is simply dropped (next-day wrap).
  always_comb begin
    w_hour_sum = 8'(r_base[H10_LSB +: BCD_W]) * 8'd10 + 8'(r_base[H1_LSB +: BCD_W])
               + 8'(r_addend[H10_LSB +: BCD_W]) * 8'd10 + 8'(r_addend[H1_LSB +: BCD_W])
               + 8'(r_carry);
    w_hour_red = (w_hour_sum >= MOD_HOUR) ? (w_hour_sum - MOD_HOUR) : w_hour_sum;
    w_hour_bcd = hour_to_bcd(w_hour_red);
  end

  // ---------------- datapath ----------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_base     <= '0;
      r_addend   <= '0;
      r_target   <= '0;
      r_carry    <= 1'b0;
      r_step     <= '0;
      r_ring_cnt <= '0;
    end else begin
      r_ring_cnt <= (r_state == ST_RING) ? (r_ring_cnt + CNT_W'(1)) : '0;
      if (w_load_start || w_load_snooze) begin
        // operands are frozen here so later input changes cannot disturb the sum
        r_base   <= i_cur_time;
        r_addend <= w_load_snooze ? SNOOZE_ADDEND : i_offset;
        r_carry  <= 1'b0;
        r_step   <= '0;
      end else if (r_state == ST_ADD && !i_cancel) begin
        case (r_step)
          3'd0:    r_target[S1_LSB  +: BCD_W] <= w_digit;
          3'd1:    r_target[S10_LSB +: BCD_W] <= w_digit;
          3'd2:    r_target[M1_LSB  +: BCD_W] <= w_digit;
          3'd3:    r_target[M10_LSB +: BCD_W] <= w_digit;
          default: r_target[H1_LSB +: 2*BCD_W] <= w_hour_bcd;
        endcase
        r_carry <= w_cout;
        r_step  <= r_step + 3'd1;
      end
    end
  end

  assign o_target = r_target;
  assign o_busy   = (r_state == ST_ADD);
  assign o_armed  = (r_state == ST_ARMED);
  assign o_alarm  = (r_state == ST_RING);

endmodule

// File: tb/tb_nap_alarm_scheduler.sv
module tb_nap_alarm_scheduler;

  logic        clk = 1'b0;
  logic        rst, start, cancel, snooze;
  logic [23:0] cur_time, offset;
  logic [23:0] target;
  logic        busy, armed, alarm;

  int n_chk  = 0;
  int n_pass = 0;
  logic [23:0] last_tgt;

  always #5 clk = ~clk;

  nap_alarm_scheduler #(.RING_LEN(16), .SNOOZE_MIN(5)) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_start   (start),
    .i_cancel  (cancel),
    .i_snooze  (snooze),
    .i_cur_time(cur_time),
    .i_offset  (offset),
    .o_target  (target),
    .o_busy    (busy),
    .o_armed   (armed),
    .o_alarm   (alarm)
  );

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %06h expected %06h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: time as seconds of day
  function automatic int to_sec(input logic [23:0] t);
    return (t[23:20] * 10 + t[19:16]) * 3600 + (t[15:12] * 10 + t[11:8]) * 60
         + t[7:4] * 10 + t[3:0];
  endfunction

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, sec;
    h = s / 3600; m = (s / 60) % 60; sec = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
  endfunction

  function automatic logic [23:0] model_add(input logic [23:0] b, input logic [23:0] o);
    return to_bcd((to_sec(b) + to_sec(o)) % 86400);
  endfunction

  function automatic logic [23:0] rand_time();
    return to_bcd($urandom_range(0, 86399));
  endfunction

  // Start an add, scramble live inputs, verify the 5-cycle timing and result.
  task automatic do_add(input string tag, input logic [23:0] b, input logic [23:0] o);
    logic [23:0] exp;
    exp = model_add(b, o);
    cur_time = b; offset = o; start = 1'b1;
    tick();
    start = 1'b0; offset = ~o; cur_time = exp ^ 24'h000001;
    chk({tag, "_busy0"}, {23'd0, busy}, 24'd1);
    chk({tag, "_noring"}, {23'd0, alarm}, 24'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk({tag, "_busy_armed"}, {22'd0, busy, armed}, 24'd2);
    end
    tick();
    chk({tag, "_armed"}, {22'd0, busy, armed}, 24'd1);
    chk({tag, "_target"}, target, exp);
    last_tgt = exp;
  endtask

  task automatic ring_up();
    do_add("ring_setup", 24'h065950, 24'h000010);
    cur_time = 24'h070000;
    tick();
    chk("ring_start", {21'd0, busy, armed, alarm}, 24'd1);
  endtask

  initial begin
    rst = 1'b1; start = 0; cancel = 0; snooze = 0;
    cur_time = 24'h111111; offset = 24'h0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_target", target, 24'h0);
    chk("reset_flags", {21'd0, busy, armed, alarm}, 24'd0);

    do_add("t1", 24'h123456, 24'h000510);
    chk("t1_const", target, 24'h124006);
    do_add("wrap", 24'h235959, 24'h000001);
    chk("wrap_const", target, 24'h000000);
    do_add("hour", 24'h230000, 24'h235959);
    chk("hour_const", target, 24'h225959);

    for (int i = 0; i < 20; i++) begin
      logic [23:0] b, o;
      b = rand_time(); o = rand_time();
      do_add("rand", b, o);
    end

    // Ring window
    ring_up();
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("ring_hold", {23'd0, alarm}, 24'd1);
    end
    tick();
    chk("ring_end", {21'd0, busy, armed, alarm}, 24'd0);
    chk("ring_end_tgt", target, 24'h070000);

    // Snooze from ring
    ring_up();
    tick(); tick();
    cur_time = 24'h070003; snooze = 1'b1;
    tick();
    snooze = 1'b0; cur_time = 24'h070004;
    chk("snz_busy0", {21'd0, busy, armed, alarm}, 24'd4);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("snz_busy", {21'd0, busy, armed, alarm}, 24'd4);
    end
    tick();
    chk("snz_armed", {21'd0, busy, armed, alarm}, 24'd2);
    chk("snz_target", target, 24'h070503);

    // Snooze outside RING does nothing
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    chk("snz_ignored", {21'd0, busy, armed, alarm}, 24'd2);

    // Start and match together: start wins (base equals current target)
    do_add("startwins", 24'h070503, 24'h000001);
    chk("startwins_tgt", target, 24'h070504);

    // Cancel during ADD step 2: only s1/s10 of the new sum were written
    cur_time = 24'h123456; offset = 24'h000510; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_flags", {21'd0, busy, armed, alarm}, 24'd0);
    chk("cancel_target", target, {last_tgt[23:8], 8'h06});

    // Reset during RING
    ring_up();
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ring_flags", {21'd0, busy, armed, alarm}, 24'd0);
    chk("rst_ring_tgt", target, 24'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
